// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor:
// mode encoding, stage-count helper, signed limit helpers and the
// single-bit full-adder cell that every ripple segment is built from.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the signed-limit helpers can describe.
  localparam int MAX_W = 64;

  // Number of pipeline stages for a given width and segment size.
  function automatic int calc_nstg(input int n_bit, input int seg);
    return (seg < 1) ? 1 : (n_bit / seg);
  endfunction

  // Largest signed value of width w, zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] smax_val(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value of width w, as an MAX_W-bit pattern.
  function automatic logic [MAX_W-1:0] smin_val(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/fa_seg.sv
// W-bit combinational ripple segment built from the full-adder cell.
// Besides the carry-out it exposes the carry into its MSB, which the
// final stage needs for signed-overflow detection.
module fa_seg
  import adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);

  logic [W:0] carry;

  // Ripple the carry through W full-adder cells, LSB first.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < W; i++) begin
      {carry[i+1], sum[i]} = fa(a[i], b[i], carry[i]);
    end
  end

  assign c_out = carry[W];
  assign c_msb = carry[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N_BIT adder/subtractor. The carry chain is cut into SEG-bit
// ripple segments with one register stage per segment; all stages move
// together under a single global enable.
//
// Handshake: an operand transfer happens on a rising edge where
// in_valid & in_ready; a result transfer where out_valid & out_ready.
// in_ready = adv = ~out_valid | out_ready, so the whole pipe holds while
// the consumer stalls a valid result, and bubbles are never collapsed.
//
// Optional build macro PIPELINED_ADDSUB_SAT_EN: on signed overflow the
// result saturates to the signed limit in the direction of the true
// result (mux lives in the final stage). Undefined: result wraps.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int N_BIT = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] A,
  input  logic [N_BIT-1:0] B,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] sum_res,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSTG = calc_nstg(N_BIT, SEG);
  localparam int LAST = NSTG - 1;

  if (SEG < 1 || (N_BIT % SEG) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: N_BIT must be a positive multiple of SEG");
  end

  localparam logic [N_BIT-1:0] ONES     = '1;
  localparam logic [N_BIT-1:0] SEG_MASK = ONES >> (N_BIT - SEG);

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [MAX_W-1:0] SMAX_W = smax_val(N_BIT);
  localparam logic [MAX_W-1:0] SMIN_W = smin_val(N_BIT);
  localparam logic [N_BIT-1:0] SMAX   = SMAX_W[N_BIT-1:0];
  localparam logic [N_BIT-1:0] SMIN   = SMIN_W[N_BIT-1:0];
`endif

  logic adv;

  // Per-stage inputs (_d), next partial sum (_n) and registers (_q).
  logic [N_BIT-1:0] a_d [NSTG];
  logic [N_BIT-1:0] b_d [NSTG];
  logic [N_BIT-1:0] s_d [NSTG];
  logic [N_BIT-1:0] s_n [NSTG];
  logic             c_d [NSTG];
  logic             v_d [NSTG];
  logic [N_BIT-1:0] a_q [NSTG];
  logic [N_BIT-1:0] b_q [NSTG];
  logic [N_BIT-1:0] s_q [NSTG];
  logic             c_q [NSTG];
  logic             v_q [NSTG];
  logic [SEG-1:0]   seg_sum [NSTG];
  logic             seg_c   [NSTG];
  logic             seg_cm  [NSTG];
  logic             ovf_q;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [N_BIT-1:0] s_raw;

    if (k == 0) begin : g_first
      // Subtract is A + ~B + 1; c_in only matters in add mode.
      assign a_d[k] = A;
      assign b_d[k] = (sub == OP_SUB) ? ~B : B;
      assign c_d[k] = (sub == OP_SUB) ? 1'b1 : c_in;
      assign s_d[k] = '0;
      assign v_d[k] = in_valid;
    end else begin : g_next
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign c_d[k] = c_q[k-1];
      assign s_d[k] = s_q[k-1];
      assign v_d[k] = v_q[k-1];
    end

    fa_seg #(.W(SEG)) u_seg (
      .a     (a_d[k][k*SEG +: SEG]),
      .b     (b_d[k][k*SEG +: SEG]),
      .c_in  (c_d[k]),
      .sum   (seg_sum[k]),
      .c_out (seg_c[k]),
      .c_msb (seg_cm[k])
    );

    // Merge this stage's segment into the partial sum carried so far.
    assign s_raw = (s_d[k] & ~(SEG_MASK << (k*SEG)))
                 | (N_BIT'(seg_sum[k]) << (k*SEG));

    if (k == LAST) begin : g_last
`ifdef PIPELINED_ADDSUB_SAT_EN
      // Overflow needs equal operand signs, so A's MSB gives the direction.
      assign s_n[k] = (seg_c[k] ^ seg_cm[k])
                    ? (a_d[k][N_BIT-1] ? SMIN : SMAX)
                    : s_raw;
`else
      assign s_n[k] = s_raw;
`endif
    end else begin : g_mid
      assign s_n[k] = s_raw;
    end

    // Stage register: shifts with the global enable; bubbles carry zeros.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else if (adv) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_n[k];
          c_q[k] <= seg_c[k];
        end else begin
          a_q[k] <= '0;
          b_q[k] <= '0;
          s_q[k] <= '0;
          c_q[k] <= 1'b0;
        end
      end
    end
  end

  // Signed overflow captured alongside the final-stage result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= v_d[LAST] & (seg_c[LAST] ^ seg_cm[LAST]);
    end
  end

  assign out_valid = v_q[LAST];
  assign sum_res   = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign ovf       = ovf_q;

endmodule
